tpu_sequencer: RTL and testbench

Instruction decoder and phase sequencer for the N×N systolic-array datapath. It accepts the 16-bit instruction word (3-bit opcode, 13-bit immediate) and holds the base-address register. It expands each multi-cycle opcode into per-cycle strobes:
- weight-row loads
- input-row loads
- skewed compute feed with accumulator drain
- the new STORE of accumulator rows back into the unified buffer

It sits between the instruction source and the memory, MMU, input-setup and accumulator blocks inside the top-level module.

---
 rtl/tpu_pkg.sv | 35 +++
 rtl/tpu_sequencer_beat_counter.sv | 43 ++++
 rtl/tpu_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_tpu_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array instruction sequencer: instruction
// field widths, opcode and phase encodings, and a phase classification helper.
package tpu_pkg;

    localparam int OPCODE_W = 3;
    localparam int IMM_W    = 13;
    localparam int INSTR_W  = OPCODE_W + IMM_W;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP         = 3'd0,
        OP_LOAD_ADDR   = 3'd1,
        OP_LOAD_WEIGHT = 3'd2,
        OP_LOAD_INPUT  = 3'd3,
        OP_COMPUTE     = 3'd4,
        OP_STORE       = 3'd5,
        OP_RSV6        = 3'd6,
        OP_RSV7        = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_LOAD_W        = 3'd1,
        ST_LOAD_IN       = 3'd2,
        ST_COMPUTE_FEED  = 3'd3,
        ST_COMPUTE_DRAIN = 3'd4,
        ST_STORE         = 3'd5
    } state_e;

    // Phases whose last beat is also the last beat of the whole operation.
    function automatic logic is_final_phase(input state_e s);
        return (s == ST_LOAD_W) || (s == ST_LOAD_IN) ||
               (s == ST_COMPUTE_DRAIN) || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/tpu_sequencer_beat_counter.sv
// Beat counter for one sequencer phase: reloaded with a beat count on phase
// entry, advanced once per beat, flags the final beat of the phase.
module beat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] term,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt_next,
    output logic             last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_q;

    // Beat index for the coming cycle; a reload restarts the phase at beat 0.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = '0;
        end else if (advance) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Beat index and the terminal count of the phase in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            term_q <= '0;
        end else begin
            cnt <= cnt_next;
            if (load) begin
                term_q <= term;
            end
        end
    end

    assign last = (cnt == term_q - CNT_W'(1));

endmodule

// File: rtl/tpu_sequencer.sv
// Instruction decoder and phase sequencer for the NxN systolic array. Accepts
// one instruction while idle, holds the base-address register and expands
// multi-cycle opcodes into registered per-beat strobes.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INSTR_W-1:0]      instruction,
    output logic                    instr_ready,
    output logic                    instr_err,
    output logic [ADDR_W-1:0]       base_addr,
    output logic                    ub_rd_en,
    output logic [ADDR_W-1:0]       ub_rd_addr,
    output logic                    ub_wr_en,
    output logic [ADDR_W-1:0]       ub_wr_addr,
    output logic                    wt_load_en,
    output logic                    in_load_en,
    output logic [$clog2(N)-1:0]    row_sel,
    output logic                    acc_clr,
    output logic                    feed_valid,
    output logic [$clog2(2*N)-1:0]  feed_step,
    output logic                    op_done
);

    localparam int RS_W  = $clog2(N);
    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] ROW_BEATS  = CNT_W'(N);
    localparam logic [CNT_W-1:0] FEED_BEATS = CNT_W'(2 * N - 1);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(N - 1);

    opcode_e           opcode;
    logic [IMM_W-1:0]  imm;
    state_e            state, state_nx;
    logic [ADDR_W-1:0] base_nx;
    logic              weights_loaded, inputs_loaded;
    logic              set_w, set_i, clr_i;
    logic              err_nx;
    logic              ctr_load, ctr_adv, ctr_last;
    logic [CNT_W-1:0]  ctr_term, cnt_nx;

    logic              rd_en_d, wr_en_d, wt_d, in_d, clr_d, fv_d, done_d;
    logic [ADDR_W-1:0] row_addr_d;
    logic [RS_W-1:0]   row_d;
    logic [CNT_W-1:0]  step_d;

    assign opcode = opcode_e'(instruction[INSTR_W-1:IMM_W]);
    assign imm    = instruction[IMM_W-1:0];

    beat_counter #(
        .CNT_W(CNT_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (ctr_load),
        .term    (ctr_term),
        .advance (ctr_adv),
        .cnt_next(cnt_nx),
        .last    (ctr_last)
    );

    // Decode in IDLE, step through the beats of each phase otherwise.
    always_comb begin
        state_nx = state;
        base_nx  = base_addr;
        err_nx   = 1'b0;
        ctr_load = 1'b0;
        ctr_term = '0;
        ctr_adv  = 1'b0;
        set_w    = 1'b0;
        set_i    = 1'b0;
        clr_i    = 1'b0;
        case (state)
            ST_IDLE: begin
                case (opcode)
                    OP_NOP: ;
                    OP_LOAD_ADDR: begin
                        if (imm[IMM_W-1:ADDR_W] != '0) begin
                            err_nx = 1'b1;
                        end else begin
                            base_nx = imm[ADDR_W-1:0];
                        end
                    end
                    OP_LOAD_WEIGHT: begin
                        state_nx = ST_LOAD_W;
                        ctr_load = 1'b1;
                        ctr_term = ROW_BEATS;
                    end
                    OP_LOAD_INPUT: begin
                        state_nx = ST_LOAD_IN;
                        ctr_load = 1'b1;
                        ctr_term = ROW_BEATS;
                    end
                    OP_COMPUTE: begin
                        if (weights_loaded && inputs_loaded) begin
                            state_nx = ST_COMPUTE_FEED;
                            ctr_load = 1'b1;
                            ctr_term = FEED_BEATS;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                    OP_STORE: begin
                        state_nx = ST_STORE;
                        ctr_load = 1'b1;
                        ctr_term = ROW_BEATS;
                    end
                    default: err_nx = 1'b1;
                endcase
            end
            ST_COMPUTE_FEED: begin
                if (ctr_last) begin
                    state_nx = ST_COMPUTE_DRAIN;
                    ctr_load = 1'b1;
                    ctr_term = ROW_BEATS;
                end else begin
                    ctr_adv = 1'b1;
                end
            end
            default: begin
                if (ctr_last) begin
                    state_nx = ST_IDLE;
                    set_w    = (state == ST_LOAD_W);
                    set_i    = (state == ST_LOAD_IN);
                    clr_i    = (state == ST_COMPUTE_DRAIN);
                end else begin
                    ctr_adv = 1'b1;
                end
            end
        endcase
    end

    // Strobe values for the beat that the next clock edge starts.
    always_comb begin
        rd_en_d    = (state_nx == ST_LOAD_W) || (state_nx == ST_LOAD_IN);
        wr_en_d    = (state_nx == ST_STORE);
        wt_d       = (state_nx == ST_LOAD_W);
        in_d       = (state_nx == ST_LOAD_IN);
        fv_d       = (state_nx == ST_COMPUTE_FEED);
        clr_d      = (state == ST_IDLE) && (state_nx == ST_COMPUTE_FEED);
        done_d     = is_final_phase(state_nx) && (cnt_nx == LAST_ROW);
        row_addr_d = base_addr + ADDR_W'(cnt_nx) * ADDR_W'(N);
        row_d      = (rd_en_d || wr_en_d) ? cnt_nx[RS_W-1:0] : '0;
        step_d     = fv_d ? cnt_nx : '0;
    end

    // Phase state, base address and operand-loaded flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            base_addr      <= '0;
            weights_loaded <= 1'b0;
            inputs_loaded  <= 1'b0;
        end else begin
            state     <= state_nx;
            base_addr <= base_nx;
            if (set_w) begin
                weights_loaded <= 1'b1;
            end
            if (set_i) begin
                inputs_loaded <= 1'b1;
            end else if (clr_i) begin
                inputs_loaded <= 1'b0;
            end
        end
    end

    // Output registers; a reset drops every strobe at once and reopens the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_ready <= 1'b1;
            instr_err   <= 1'b0;
            ub_rd_en    <= 1'b0;
            ub_rd_addr  <= '0;
            ub_wr_en    <= 1'b0;
            ub_wr_addr  <= '0;
            wt_load_en  <= 1'b0;
            in_load_en  <= 1'b0;
            row_sel     <= '0;
            acc_clr     <= 1'b0;
            feed_valid  <= 1'b0;
            feed_step   <= '0;
            op_done     <= 1'b0;
        end else begin
            instr_ready <= (state_nx == ST_IDLE);
            instr_err   <= err_nx;
            ub_rd_en    <= rd_en_d;
            ub_rd_addr  <= rd_en_d ? row_addr_d : '0;
            ub_wr_en    <= wr_en_d;
            ub_wr_addr  <= wr_en_d ? row_addr_d : '0;
            wt_load_en  <= wt_d;
            in_load_en  <= in_d;
            row_sel     <= row_d;
            acc_clr     <= clr_d;
            feed_valid  <= fv_d;
            feed_step   <= step_d;
            op_done     <= done_d;
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer (N=2, ADDR_W=6): directed instructions push
// expected strobe beats, a monitor pops one whenever the DUT asserts a strobe.
module tb_tpu_sequencer;

    localparam logic [2:0] OP_LA = 3'd1, OP_LW = 3'd2, OP_LI = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4, OP_ST = 3'd5, OP_BAD = 3'd7;
    // Flag order: {rd, wr, wt, in, clr, fv, err, done}
    localparam logic [7:0] F_RD = 8'h80, F_WR = 8'h40, F_WT = 8'h20, F_IN = 8'h10;
    localparam logic [7:0] F_CLR = 8'h08, F_FV = 8'h04, F_ERR = 8'h02, F_DONE = 8'h01;

    typedef struct {
        string      nm;
        int         cyc;
        logic [7:0] flags;
        logic [5:0] addr;
        logic       row;
        logic [1:0] step;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = '0;
    logic        instr_ready, instr_err, ub_rd_en, ub_wr_en, wt_load_en, in_load_en;
    logic        acc_clr, feed_valid, op_done;
    logic [5:0]  base_addr, ub_rd_addr, ub_wr_addr;
    logic [0:0]  row_sel;
    logic [1:0]  feed_step;

    exp_t        sb[$];
    int          edge_n = 0;
    int          passed = 0;
    int          total = 0;

    tpu_sequencer #(.N(2), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .instr_ready(instr_ready),
        .instr_err  (instr_err),
        .base_addr  (base_addr),
        .ub_rd_en   (ub_rd_en),
        .ub_rd_addr (ub_rd_addr),
        .ub_wr_en   (ub_wr_en),
        .ub_wr_addr (ub_wr_addr),
        .wt_load_en (wt_load_en),
        .in_load_en (in_load_en),
        .row_sel    (row_sel),
        .acc_clr    (acc_clr),
        .feed_valid (feed_valid),
        .feed_step  (feed_step),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle with any strobe high consumes one expected beat.
    always @(negedge clk) begin
        logic [7:0] act;
        logic       ok;
        exp_t       e;
        act = {ub_rd_en, ub_wr_en, wt_load_en, in_load_en, acc_clr, feed_valid, instr_err, op_done};
        if (act != 8'h00) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_strobe edge=%0d got flags=%b want none", edge_n, act);
            end else begin
                e  = sb.pop_front();
                ok = (act == e.flags) && (edge_n == e.cyc);
                if (ub_rd_en && ub_rd_addr != e.addr) ok = 1'b0;
                if (ub_wr_en && ub_wr_addr != e.addr) ok = 1'b0;
                if ((ub_rd_en || ub_wr_en) && row_sel != e.row) ok = 1'b0;
                if (feed_valid && feed_step != e.step) ok = 1'b0;
                if (ok) begin
                    passed++;
                end else begin
                    $display("FAIL %s got edge=%0d flags=%b rd=%0d wr=%0d row=%0d step=%0d want edge=%0d flags=%b addr=%0d row=%0d step=%0d",
                             e.nm, edge_n, act, ub_rd_addr, ub_wr_addr, row_sel, feed_step,
                             e.cyc, e.flags, e.addr, e.row, e.step);
                end
            end
        end
    end

    task automatic push(input string nm, input int cyc, input logic [7:0] flags,
                        input logic [5:0] addr, input logic row, input logic [1:0] step);
        exp_t e;
        e.nm = nm; e.cyc = cyc; e.flags = flags; e.addr = addr; e.row = row; e.step = step;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s got=%0h want=%0h", nm, act, want);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge; k is the edge that samples it.
    task automatic send(input logic [2:0] op, input logic [12:0] imm, output int k);
        instruction = {op, imm};
        k = edge_n + 1;
        @(posedge clk);
        #1;
        instruction = '0;
    endtask

    initial begin
        int k;
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick(1);
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_base", 32'(base_addr), 32'd0);
        chk("reset_strobes", 32'({ub_rd_en, ub_wr_en, wt_load_en, in_load_en, acc_clr,
                                  feed_valid, instr_err, op_done, row_sel, feed_step}), 32'd0);

        // LOAD_ADDR 15 then LOAD_WEIGHT back to back
        send(OP_LA, 13'd15, k);
        chk("la15_base", 32'(base_addr), 32'd15);
        send(OP_LW, 13'd0, k);
        push("lw_beat0", k,     F_RD | F_WT,          6'd15, 1'b0, 2'd0);
        push("lw_beat1", k + 1, F_RD | F_WT | F_DONE, 6'd17, 1'b1, 2'd0);
        chk("lw_ready_k", 32'(instr_ready), 32'd0);
        tick(1);
        chk("lw_ready_k1", 32'(instr_ready), 32'd0);
        tick(1);
        chk("lw_ready_k2", 32'(instr_ready), 32'd1);

        // LOAD_ADDR 30 + LOAD_INPUT
        send(OP_LA, 13'd30, k);
        send(OP_LI, 13'd0, k);
        push("li_beat0", k,     F_RD | F_IN,          6'd30, 1'b0, 2'd0);
        push("li_beat1", k + 1, F_RD | F_IN | F_DONE, 6'd32, 1'b1, 2'd0);
        tick(2);

        // COMPUTE: three feed steps, two drain cycles
        send(OP_CMP, 13'd0, k);
        push("cmp_feed0", k,     F_CLR | F_FV, 6'd0, 1'b0, 2'd0);
        push("cmp_feed1", k + 1, F_FV,         6'd0, 1'b0, 2'd1);
        push("cmp_feed2", k + 2, F_FV,         6'd0, 1'b0, 2'd2);
        push("cmp_done",  k + 4, F_DONE,       6'd0, 1'b0, 2'd0);
        chk("cmp_ready_k", 32'(instr_ready), 32'd0);
        tick(4);
        chk("cmp_ready_k4", 32'(instr_ready), 32'd0);
        tick(1);
        chk("cmp_ready_k5", 32'(instr_ready), 32'd1);

        // Second COMPUTE without reloading inputs is refused
        send(OP_CMP, 13'd0, k);
        push("cmp_refused", k, F_ERR, 6'd0, 1'b0, 2'd0);
        chk("cmp_refused_ready", 32'(instr_ready), 32'd1);
        tick(2);

        // Address wrap on STORE
        send(OP_LA, 13'd63, k);
        send(OP_ST, 13'd0, k);
        push("st_beat0", k,     F_WR,          6'd63, 1'b0, 2'd0);
        push("st_beat1", k + 1, F_WR | F_DONE, 6'd1,  1'b1, 2'd0);
        tick(2);

        // LOAD_ADDR with immediate above the address range
        send(OP_LA, 13'h0040, k);
        push("la_range_err", k, F_ERR, 6'd0, 1'b0, 2'd0);
        chk("la_range_base", 32'(base_addr), 32'd63);
        tick(1);

        // Illegal opcode
        send(OP_BAD, 13'd0, k);
        push("bad_opcode", k, F_ERR, 6'd0, 1'b0, 2'd0);
        chk("bad_opcode_ready", 32'(instr_ready), 32'd1);
        tick(1);

        // LOAD_WEIGHT presented again while busy is dropped
        send(OP_LW, 13'd0, k);
        push("lw2_beat0", k,     F_RD | F_WT,          6'd63, 1'b0, 2'd0);
        push("lw2_beat1", k + 1, F_RD | F_WT | F_DONE, 6'd1,  1'b1, 2'd0);
        instruction = {OP_LW, 13'd0};
        tick(1);
        instruction = '0;
        tick(3);

        // Reset in the middle of COMPUTE
        send(OP_LI, 13'd0, k);
        push("li2_beat0", k,     F_RD | F_IN,          6'd63, 1'b0, 2'd0);
        push("li2_beat1", k + 1, F_RD | F_IN | F_DONE, 6'd1,  1'b1, 2'd0);
        tick(2);
        send(OP_CMP, 13'd0, k);
        push("rst_feed0", k,     F_CLR | F_FV, 6'd0, 1'b0, 2'd0);
        push("rst_feed1", k + 1, F_FV,         6'd0, 1'b0, 2'd1);
        tick(1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_strobes", 32'({ub_rd_en, ub_wr_en, wt_load_en, in_load_en, acc_clr,
                                   feed_valid, instr_err, op_done, row_sel, feed_step}), 32'd0);
        chk("midrst_base", 32'(base_addr), 32'd0);
        tick(2);
        @(negedge clk) reset = 1'b1;
        tick(1);
        chk("postrst_ready", 32'(instr_ready), 32'd1);
        chk("postrst_base", 32'(base_addr), 32'd0);
        tick(5);

        // Flags were cleared by reset
        send(OP_CMP, 13'd0, k);
        push("postrst_cmp_err", k, F_ERR, 6'd0, 1'b0, 2'd0);
        tick(3);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
